// File: rtl/common_pkg.sv
// Shared endpoint definitions: default parameter values, the default-width
// packet layout {addr, data}, and a small round-robin helper.
package common_pkg;

    localparam int DEFAULT_N             = 4;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_D_W           = 8;
    localparam int DEFAULT_VC_FIFO_DEPTH = 4;
    localparam int DEFAULT_A_W           = $clog2(DEFAULT_N) + 1;

    typedef struct packed {
        logic [DEFAULT_A_W-1:0] addr;
        logic [DEFAULT_D_W-1:0] data;
    } endpoint_packet_t;

    // Next round-robin position after 'cur' among 'n' channels.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/noc_ep_vc_fifo.sv
// Single-VC synchronous FIFO holding DEPTH-1 packets.
// Ports:
//   clk, rst_n  clock, async active-low reset (empties the FIFO)
//   push        write push_data (dropped when full unless popping this cycle)
//   push_data   packet to write
//   pop         remove the head entry (ignored when empty)
//   full/empty  occupancy flags
//   head        oldest entry, valid when !empty
module noc_ep_vc_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int ENTRIES = DEPTH - 1;
    localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W   = $clog2(ENTRIES + 1);

    logic [W-1:0]     mem [ENTRIES];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(ENTRIES));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A pop frees the slot the same cycle, so a full FIFO can still accept.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_leaf_endpoint.sv
// Leaf-port network interface of the t-switch binary tree NoC.
// Injection side holds per-VC credits and registers accepted client packets
// onto the tree leaf receive port for one cycle. Ejection side buffers tree
// packets in per-VC FIFOs, round-robins them to the client and returns one
// credit per consumed packet.
// Optional build macro NOC_EP_STATS_EN adds stat_tx_pkts, stat_rx_pkts and
// stat_stall_cycles counters.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready/in_vc/in_addr/in_data   client injection
//   noc_tx_vc_target/noc_tx_packet/noc_tx_credit  to/from tree receive port
//   noc_rx_vc_target/noc_rx_packet/noc_rx_credit  from/to tree transmit port
//   out_valid/out_ready/out_vc/out_addr/out_data  client ejection
module noc_leaf_endpoint
    import common_pkg::*;
#(
    parameter  int N             = DEFAULT_N,
    parameter  int VC_W          = DEFAULT_VC_W,
    parameter  int D_W           = DEFAULT_D_W,
    parameter  int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    localparam int A_W           = $clog2(N) + 1,
    localparam int VCI_W         = (VC_W > 1) ? $clog2(VC_W) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VCI_W-1:0]   in_vc,
    input  logic [A_W-1:0]     in_addr,
    input  logic [D_W-1:0]     in_data,
    output logic [VC_W-1:0]    noc_tx_vc_target,
    output logic [A_W+D_W-1:0] noc_tx_packet,
    input  logic [VC_W-1:0]    noc_tx_credit,
    input  logic [VC_W-1:0]    noc_rx_vc_target,
    input  logic [A_W+D_W-1:0] noc_rx_packet,
    output logic [VC_W-1:0]    noc_rx_credit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VCI_W-1:0]   out_vc,
    output logic [A_W-1:0]     out_addr,
    output logic [D_W-1:0]     out_data
`ifdef NOC_EP_STATS_EN
    ,
    output logic [31:0]        stat_tx_pkts,
    output logic [31:0]        stat_rx_pkts,
    output logic [31:0]        stat_stall_cycles
`endif
);
    localparam int PW     = A_W + D_W;
    localparam int CR_W   = $clog2(VC_FIFO_DEPTH);
    localparam int CR_MAX = VC_FIFO_DEPTH - 1;

    // ---------------- injection ----------------
    logic [VC_W-1:0][CR_W-1:0] credit;
    logic [VC_W-1:0][CR_W-1:0] credit_nxt;
    logic                      accept;
    logic [VC_W-1:0]           take;

    assign in_ready = (credit[in_vc] != '0);
    assign accept   = in_valid && in_ready;
    assign take     = accept ? (VC_W'(1) << in_vc) : '0;

    always_comb begin
        credit_nxt = credit;
        for (int v = 0; v < VC_W; v++) begin
            case ({take[v], noc_tx_credit[v]})
                2'b10: credit_nxt[v] = credit[v] - CR_W'(1);
                // Return at the maximum is illegal; hold rather than wrap.
                2'b01: if (credit[v] != CR_W'(CR_MAX)) credit_nxt[v] = credit[v] + CR_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VC_W; v++) credit[v] <= CR_W'(CR_MAX);
            noc_tx_vc_target <= '0;
            noc_tx_packet    <= '0;
        end else begin
            credit           <= credit_nxt;
            noc_tx_vc_target <= take;
            noc_tx_packet    <= accept ? {in_addr, in_data} : '0;
        end
    end

    // ---------------- ejection ----------------
    logic [VC_W-1:0]         fifo_full;
    logic [VC_W-1:0]         fifo_empty;
    logic [VC_W-1:0][PW-1:0] fifo_head;
    logic [VC_W-1:0]         pop;
    logic [VCI_W-1:0]        rr;
    logic [VCI_W-1:0]        pick;
    logic [VCI_W-1:0]        sel;
    logic [VCI_W-1:0]        lock_vc;
    logic                    locked;
    logic                    hs;

    for (genvar v = 0; v < VC_W; v++) begin : g_fifo
        noc_ep_vc_fifo #(.W(PW), .DEPTH(VC_FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (noc_rx_vc_target[v]),
            .push_data (noc_rx_packet),
            .pop       (pop[v]),
            .full      (fifo_full[v]),
            .empty     (fifo_empty[v]),
            .head      (fifo_head[v])
        );
    end

    // First non-empty VC at or after the rr pointer.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < VC_W; i++) begin
            idx = int'(rr) + i;
            if (idx >= VC_W) idx = idx - VC_W;
            if (!found && !fifo_empty[idx]) begin
                found = 1'b1;
                pick  = VCI_W'(idx);
            end
        end
    end

    // Once offered and stalled, the choice is frozen so a newly filled VC
    // cannot swap the packet under the client.
    assign sel       = locked ? lock_vc : pick;
    assign out_valid = |(~fifo_empty);
    assign out_vc    = sel;
    assign {out_addr, out_data} = fifo_head[sel];
    assign hs        = out_valid && out_ready;
    assign pop       = hs ? (VC_W'(1) << sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr            <= '0;
            locked        <= 1'b0;
            lock_vc       <= '0;
            noc_rx_credit <= '0;
        end else begin
            if (hs) rr <= VCI_W'(rr_next(int'(sel), VC_W));
            locked        <= out_valid && !out_ready;
            lock_vc       <= sel;
            noc_rx_credit <= pop;
        end
    end

`ifdef NOC_EP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tx_pkts      <= '0;
            stat_rx_pkts      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_tx_pkts      <= stat_tx_pkts + 32'(accept);
            stat_rx_pkts      <= stat_rx_pkts + 32'(hs);
            stat_stall_cycles <= stat_stall_cycles + 32'(in_valid && !in_ready);
        end
    end
`endif

`ifndef SYNTHESIS
    a_rx_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(noc_rx_vc_target));
    for (genvar v = 0; v < VC_W; v++) begin : g_chk
        a_credit_ovf: assert property (@(posedge clk) disable iff (!rst_n)
            !(noc_tx_credit[v] && !take[v] && credit[v] == CR_W'(CR_MAX)));
        a_rx_full: assert property (@(posedge clk) disable iff (!rst_n)
            !(noc_rx_vc_target[v] && fifo_full[v] && !pop[v]));
    end
`endif

endmodule
